// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA plot arbiter and related drawing-engine logic.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REL
   } arb_state_t;

   localparam int unsigned VGA_XW    = 8;
   localparam int unsigned VGA_YW    = 7;
   localparam int unsigned VGA_CW    = 3;
   localparam int unsigned SCR_W_DEF = 160;
   localparam int unsigned SCR_H_DEF = 120;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr_i, wrapping at N_ENG.
module rr_pick
   import vga_pkg::*;
#(
   parameter int unsigned N_ENG = 3
) (
   input  logic [N_ENG-1:0] req_i,
   input  logic [2:0]       rr_ptr_i,
   output logic [2:0]       winner_o,
   output logic             valid_o
);

   logic [7:0] req_pad;

   // Scan from farthest to nearest so the nearest requester after the pointer wins last.
   always_comb begin
      logic [2:0] idx;
      req_pad  = 8'(req_i);
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = '0;
      for (int k = N_ENG; k >= 1; k--) begin
         idx = 3'((int'(rr_ptr_i) + k) % N_ENG);
         if (req_pad[idx]) begin
            winner_o = idx;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter pixel port for N_ENG start/done drawing engines.
// Define VGA_CLIP_EN to suppress forwarded plots that fall outside SCR_W x SCR_H.
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned N_ENG = 3,
   parameter int unsigned SCR_W = SCR_W_DEF,
   parameter int unsigned SCR_H = SCR_H_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_ENG-1:0]         req_i,
   output logic [N_ENG-1:0]         ack_o,
   output logic                     aborted_o,
   output logic [N_ENG-1:0]         eng_start_o,
   input  logic [N_ENG-1:0]         eng_done_i,
   input  logic [N_ENG*VGA_XW-1:0]  eng_x_i,
   input  logic [N_ENG*VGA_YW-1:0]  eng_y_i,
   input  logic [N_ENG*VGA_CW-1:0]  eng_colour_i,
   input  logic [N_ENG-1:0]         eng_plot_i,
   output logic [VGA_XW-1:0]        vga_x_o,
   output logic [VGA_YW-1:0]        vga_y_o,
   output logic [VGA_CW-1:0]        vga_colour_o,
   output logic                     vga_plot_o,
   output logic                     busy_o,
   output logic [2:0]               grant_id_o
);

`ifdef VGA_CLIP_EN
   localparam bit ClipEn = 1'b1;
`else
   localparam bit ClipEn = 1'b0;
`endif

   arb_state_t        state_q, state_d;
   logic [2:0]        rr_ptr_q, rr_ptr_d;
   logic [2:0]        grant_q, grant_d;
   logic              ack_pend_q, ack_pend_d;
   logic [VGA_XW-1:0] vga_x_q, vga_x_d;
   logic [VGA_YW-1:0] vga_y_q, vga_y_d;
   logic [VGA_CW-1:0] vga_c_q, vga_c_d;
   logic              vga_plot_q, vga_plot_d;

   logic [2:0]        winner;
   logic              winner_vld;
   logic [VGA_XW-1:0] x_sel;
   logic [VGA_YW-1:0] y_sel;
   logic [VGA_CW-1:0] c_sel;
   logic              plot_sel, done_sel, req_sel, on_screen;

   rr_pick #(
      .N_ENG (N_ENG)
   ) u_rr_pick (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (winner),
      .valid_o  (winner_vld)
   );

   // Granted engine's view; other engines' strobes and dones never reach the FSM.
   always_comb begin
      x_sel    = '0;
      y_sel    = '0;
      c_sel    = '0;
      plot_sel = 1'b0;
      done_sel = 1'b0;
      req_sel  = 1'b0;
      for (int i = 0; i < N_ENG; i++) begin
         if (grant_q == 3'(i)) begin
            x_sel    = eng_x_i[i*VGA_XW +: VGA_XW];
            y_sel    = eng_y_i[i*VGA_YW +: VGA_YW];
            c_sel    = eng_colour_i[i*VGA_CW +: VGA_CW];
            plot_sel = eng_plot_i[i];
            done_sel = eng_done_i[i];
            req_sel  = req_i[i];
         end
      end
      on_screen = (32'(x_sel) < SCR_W) && (32'(y_sel) < SCR_H);
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      ack_pend_d = ack_pend_q;
      unique case (state_q)
         IDLE: begin
            if (winner_vld) begin
               grant_d  = winner;
               rr_ptr_d = winner;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (done_sel) begin
               ack_pend_d = 1'b1;
               state_d    = REL;
            end else if (!req_sel) begin
               ack_pend_d = 1'b0;
               state_d    = REL;
            end
         end
         REL:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vga_x_d    = vga_x_q;
      vga_y_d    = vga_y_q;
      vga_c_d    = vga_c_q;
      vga_plot_d = 1'b0;
      if (state_q == RUN) begin
         vga_x_d    = x_sel;
         vga_y_d    = y_sel;
         vga_c_d    = c_sel;
         vga_plot_d = plot_sel && (!ClipEn || on_screen);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= 3'(N_ENG - 1);
         grant_q    <= '0;
         ack_pend_q <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         vga_c_q    <= '0;
         vga_plot_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         ack_pend_q <= ack_pend_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         vga_c_q    <= vga_c_d;
         vga_plot_q <= vga_plot_d;
      end
   end

   always_comb begin
      eng_start_o = '0;
      ack_o       = '0;
      for (int i = 0; i < N_ENG; i++) begin
         if (grant_q == 3'(i)) begin
            eng_start_o[i] = (state_q == RUN);
            ack_o[i]       = (state_q == REL) && ack_pend_q;
         end
      end
      aborted_o = (state_q == REL) && !ack_pend_q;
   end

   assign busy_o       = (state_q != IDLE);
   assign grant_id_o   = grant_q;
   assign vga_x_o      = vga_x_q;
   assign vga_y_o      = vga_y_q;
   assign vga_colour_o = vga_c_q;
   assign vga_plot_o   = vga_plot_q;

endmodule
